// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB pipeline stage: data-memory store codes,
// load type codes, the stage register layout and the bubble value.
package mem_wb_stage_pkg;

    // Data-memory store codes used by the MEM stage.
    localparam logic [1:0] DM_SB = 2'd0;
    localparam logic [1:0] DM_SH = 2'd1;
    localparam logic [1:0] DM_SW = 2'd2;

    // Load type codes; 5-7 are reserved and behave as LD_LW.
    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc8;
        logic [31:0] aluout;
        logic [31:0] dmo;
        logic [2:0]  ldctr;
        logic        memtoreg;
        logic        regwrite;
        logic [4:0]  wa;
    } mem_wb_t;

    localparam mem_wb_t MEM_WB_BUBBLE = '{
        valid:    1'b0,
        pc8:      32'd0,
        aluout:   32'd0,
        dmo:      32'd0,
        ldctr:    LD_LW,
        memtoreg: 1'b0,
        regwrite: 1'b0,
        wa:       5'd0
    };

    // True when a load of this type cannot legally start at this byte offset.
    function automatic logic ld_misaligned(input logic [2:0] ldctr, input logic [1:0] addr);
        logic bad;
        bad = 1'b0;
        if (ldctr == LD_LW && addr != 2'b00) begin
            bad = 1'b1;
        end else if ((ldctr == LD_LH || ldctr == LD_LHU) && addr[0]) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM -> WB bus: MEM-stage instruction fields in, write-back fields out.
// The adel signal exists only when MEM_WB_ALIGN_CHECK_EN is defined.
interface mem_wb_stage_if;
    import mem_wb_stage_pkg::*;

    logic        m_valid;
    logic [31:0] m_pc8;
    logic [31:0] m_aluout;
    logic [31:0] m_dmo;
    logic [2:0]  m_ldctr;
    logic        m_memtoreg;
    logic        m_regwrite;
    logic [4:0]  m_wa;

    logic        w_valid;
    logic [31:0] w_pc8;
    logic [4:0]  w_wa;
    logic        w_regwrite;
    logic [31:0] w_wd;
    logic [31:0] retired;
`ifdef MEM_WB_ALIGN_CHECK_EN
    logic        adel;

    modport master (
        output m_valid, m_pc8, m_aluout, m_dmo, m_ldctr, m_memtoreg, m_regwrite, m_wa,
        input  w_valid, w_pc8, w_wa, w_regwrite, w_wd, retired, adel
    );
    modport slave (
        input  m_valid, m_pc8, m_aluout, m_dmo, m_ldctr, m_memtoreg, m_regwrite, m_wa,
        output w_valid, w_pc8, w_wa, w_regwrite, w_wd, retired, adel
    );
`else
    modport master (
        output m_valid, m_pc8, m_aluout, m_dmo, m_ldctr, m_memtoreg, m_regwrite, m_wa,
        input  w_valid, w_pc8, w_wa, w_regwrite, w_wd, retired
    );
    modport slave (
        input  m_valid, m_pc8, m_aluout, m_dmo, m_ldctr, m_memtoreg, m_regwrite, m_wa,
        output w_valid, w_pc8, w_wa, w_regwrite, w_wd, retired
    );
`endif

endinterface

// File: rtl/mem_wb_stage_load_ext.sv
// Load extension: picks the byte/halfword addressed by addr out of the
// memory word and sign- or zero-extends it according to ldctr.
module load_ext
    import mem_wb_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  ldctr,
    output logic [31:0] data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Lane select then extension; unused low address bits are ignored.
    always_comb begin
        half_sel = addr[1] ? word[31:16] : word[15:0];
        byte_sel = word[{addr, 3'b000} +: 8];
        case (ldctr)
            LD_LH:   data = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  data = {16'd0, half_sel};
            LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  data = {24'd0, byte_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back data formation and a retired
// instruction counter. Define MEM_WB_ALIGN_CHECK_EN to add the adel
// misaligned-load flag, which also suppresses the register write.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
(
    input logic           clk,
    input logic           rst,
    input logic           stall,
    input logic           flush,
    mem_wb_stage_if.slave bus
);

    mem_wb_t     stage_d, stage_q;
    logic [31:0] retired_d, retired_q;
    logic [31:0] ld_data;
    logic        rw_base;

    // Next state: rst beats flush beats stall; retired counts valid captures.
    always_comb begin
        stage_d   = stage_q;
        retired_d = retired_q;
        if (rst) begin
            stage_d   = MEM_WB_BUBBLE;
            retired_d = 32'd0;
        end else if (flush) begin
            stage_d = MEM_WB_BUBBLE;
        end else if (!stall) begin
            stage_d.valid    = bus.m_valid;
            stage_d.pc8      = bus.m_pc8;
            stage_d.aluout   = bus.m_aluout;
            stage_d.dmo      = bus.m_dmo;
            stage_d.ldctr    = bus.m_ldctr;
            stage_d.memtoreg = bus.m_memtoreg;
            stage_d.regwrite = bus.m_regwrite;
            stage_d.wa       = bus.m_wa;
            if (bus.m_valid) begin
                retired_d = retired_q + 32'd1;
            end
        end
    end

    // Stage registers; reset is synchronous and folded into the next state.
    always_ff @(posedge clk) begin
        stage_q   <= stage_d;
        retired_q <= retired_d;
    end

    load_ext u_load_ext (
        .word  (stage_q.dmo),
        .addr  (stage_q.aluout[1:0]),
        .ldctr (stage_q.ldctr),
        .data  (ld_data)
    );

    // Write-back outputs straight from the registered fields.
    always_comb begin
        rw_base        = stage_q.regwrite & stage_q.valid & (stage_q.wa != 5'd0);
        bus.w_valid    = stage_q.valid;
        bus.w_pc8      = stage_q.pc8;
        bus.w_wa       = stage_q.wa;
        bus.w_wd       = stage_q.memtoreg ? ld_data : stage_q.aluout;
        bus.retired    = retired_q;
`ifdef MEM_WB_ALIGN_CHECK_EN
        bus.adel       = stage_q.valid & stage_q.memtoreg &
                         ld_misaligned(stage_q.ldctr, stage_q.aluout[1:0]);
        bus.w_regwrite = rw_base & ~bus.adel;
`else
        bus.w_regwrite = rw_base;
`endif
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a vector table of loads/ALU results plus
// hand-written stall, flush, counter-wrap, alignment and reset sequences.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    logic clk = 1'b0;
    logic rst, stall, flush;

    mem_wb_stage_if bus();

    mem_wb_stage dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc8;
        logic [31:0] alu;
        logic [31:0] dmo;
        logic [2:0]  ld;
        logic        mt;
        logic        rw;
        logic [4:0]  wa;
        logic [31:0] exp_wd;
        logic        exp_rw;
    } vec_t;

    localparam int NV = 16;
    vec_t        vecs[NV];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc8, input logic [31:0] alu,
                         input logic [31:0] dmo, input logic [2:0] ld, input logic mt,
                         input logic rw, input logic [4:0] wa);
        bus.m_valid    = v;
        bus.m_pc8      = pc8;
        bus.m_aluout   = alu;
        bus.m_dmo      = dmo;
        bus.m_ldctr    = ld;
        bus.m_memtoreg = mt;
        bus.m_regwrite = rw;
        bus.m_wa       = wa;
    endtask

    // One clock: inputs were set at a negedge, outputs settle by the next one.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " w_valid"}, {31'd0, bus.w_valid}, 32'd0);
        chk({tag, " w_regwrite"}, {31'd0, bus.w_regwrite}, 32'd0);
        chk({tag, " w_wa"}, {27'd0, bus.w_wa}, 32'd0);
        chk({tag, " w_pc8"}, bus.w_pc8, 32'd0);
        chk({tag, " w_wd"}, bus.w_wd, 32'd0);
        chk({tag, " retired"}, bus.retired, 32'd0);
`ifdef MEM_WB_ALIGN_CHECK_EN
        chk({tag, " adel"}, {31'd0, bus.adel}, 32'd0);
`endif
    endtask

    initial begin
        //           valid pc8        alu           dmo           ld      mt    rw    wa     exp_wd        exp_rw
        vecs[0]  = '{1'b1, 32'h0100, 32'h0000_1003, 32'h8899AABB, LD_LB,  1'b1, 1'b1, 5'd5,  32'hFFFFFF88, 1'b1};
        vecs[1]  = '{1'b1, 32'h0108, 32'h0000_1002, 32'h8899AABB, LD_LHU, 1'b1, 1'b1, 5'd6,  32'h00008899, 1'b1};
        vecs[2]  = '{1'b1, 32'h0110, 32'h0000_1002, 32'h8899AABB, LD_LH,  1'b1, 1'b1, 5'd7,  32'hFFFF8899, 1'b1};
        vecs[3]  = '{1'b1, 32'h0118, 32'h0000_1000, 32'h8899AABB, LD_LH,  1'b1, 1'b1, 5'd8,  32'hFFFFAABB, 1'b1};
        vecs[4]  = '{1'b1, 32'h0120, 32'h0000_1001, 32'h8899AABB, LD_LBU, 1'b1, 1'b1, 5'd9,  32'h000000AA, 1'b1};
        vecs[5]  = '{1'b1, 32'h0128, 32'h0000_1000, 32'h8899AABB, LD_LB,  1'b1, 1'b1, 5'd10, 32'hFFFFFFBB, 1'b1};
        vecs[6]  = '{1'b1, 32'h0130, 32'h0000_1002, 32'h8899AABB, LD_LB,  1'b1, 1'b1, 5'd11, 32'hFFFFFF99, 1'b1};
        vecs[7]  = '{1'b1, 32'h0138, 32'h0000_1003, 32'h8899AABB, LD_LBU, 1'b1, 1'b1, 5'd12, 32'h00000088, 1'b1};
        vecs[8]  = '{1'b1, 32'h0140, 32'h0000_1000, 32'h8899AABB, LD_LW,  1'b1, 1'b1, 5'd13, 32'h8899AABB, 1'b1};
        vecs[9]  = '{1'b1, 32'h0148, 32'h0000_1000, 32'h8899AABB, 3'd5,   1'b1, 1'b1, 5'd14, 32'h8899AABB, 1'b1};
        vecs[10] = '{1'b1, 32'h0150, 32'h0000_1000, 32'h8899AABB, 3'd7,   1'b1, 1'b1, 5'd15, 32'h8899AABB, 1'b1};
        vecs[11] = '{1'b1, 32'h0158, 32'h12345678, 32'h8899AABB, LD_LB,  1'b0, 1'b1, 5'd16, 32'h12345678, 1'b1};
        vecs[12] = '{1'b1, 32'h0160, 32'h0000_2000, 32'hDEADBEEF, LD_LW,  1'b0, 1'b1, 5'd0,  32'h00002000, 1'b0};
        vecs[13] = '{1'b0, 32'h0168, 32'h0000_1000, 32'h8899AABB, LD_LW,  1'b1, 1'b1, 5'd3,  32'h8899AABB, 1'b0};
        vecs[14] = '{1'b1, 32'h0170, 32'h0000_1000, 32'h00007F01, LD_LH,  1'b1, 1'b1, 5'd17, 32'h00007F01, 1'b1};
        vecs[15] = '{1'b1, 32'h0178, 32'h0000_1000, 32'h8899AABB, LD_LHU, 1'b1, 1'b0, 5'd18, 32'h0000AABB, 1'b0};

        // Reset together with stall and flush, inputs carrying a live load.
        rst = 1'b1; stall = 1'b1; flush = 1'b1;
        drive(1'b1, 32'hAAAA0000, 32'h0000_1003, 32'h8899AABB, LD_LB, 1'b1, 1'b1, 5'd5);
        step();
        step();
        chk_zero("reset");
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        exp_ret = 32'd0;

        // Vector table: one capture per entry, checked the following cycle.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].valid, vecs[i].pc8, vecs[i].alu, vecs[i].dmo, vecs[i].ld,
                  vecs[i].mt, vecs[i].rw, vecs[i].wa);
            step();
            if (vecs[i].valid) exp_ret = exp_ret + 32'd1;
            chk($sformatf("vec%0d w_wd", i), bus.w_wd, vecs[i].exp_wd);
            chk($sformatf("vec%0d w_regwrite", i), {31'd0, bus.w_regwrite}, {31'd0, vecs[i].exp_rw});
            chk($sformatf("vec%0d w_valid", i), {31'd0, bus.w_valid}, {31'd0, vecs[i].valid});
            chk($sformatf("vec%0d w_wa", i), {27'd0, bus.w_wa}, {27'd0, vecs[i].wa});
            chk($sformatf("vec%0d w_pc8", i), bus.w_pc8, vecs[i].pc8);
            chk($sformatf("vec%0d retired", i), bus.retired, exp_ret);
`ifdef MEM_WB_ALIGN_CHECK_EN
            chk($sformatf("vec%0d adel", i), {31'd0, bus.adel}, 32'd0);
`endif
        end

        // Capture one load, then hold it through three stalled cycles.
        drive(1'b1, 32'h0200, 32'h0000_1003, 32'h8899AABB, LD_LB, 1'b1, 1'b1, 5'd5);
        step();
        exp_ret = exp_ret + 32'd1;
        chk("stall pre w_wd", bus.w_wd, 32'hFFFFFF88);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0300 + i, 32'h12340000 + i, 32'h11223344, LD_LW, 1'b0, 1'b1,
                  5'(20 + i));
            step();
            chk($sformatf("stall%0d w_wd", i), bus.w_wd, 32'hFFFFFF88);
            chk($sformatf("stall%0d w_pc8", i), bus.w_pc8, 32'h0200);
            chk($sformatf("stall%0d w_wa", i), {27'd0, bus.w_wa}, 32'd5);
            chk($sformatf("stall%0d w_regwrite", i), {31'd0, bus.w_regwrite}, 32'd1);
            chk($sformatf("stall%0d retired", i), bus.retired, exp_ret);
        end
        // Flush while still stalled: the bubble wins, the counter does not move.
        flush = 1'b1;
        step();
        chk("flush w_valid", {31'd0, bus.w_valid}, 32'd0);
        chk("flush w_regwrite", {31'd0, bus.w_regwrite}, 32'd0);
        chk("flush w_wd", bus.w_wd, 32'd0);
        chk("flush w_pc8", bus.w_pc8, 32'd0);
        chk("flush retired", bus.retired, exp_ret);
        flush = 1'b0; stall = 1'b0;

        // Counter wrap from all-ones.
        drive(1'b0, 32'd0, 32'd0, 32'd0, LD_LW, 1'b0, 1'b0, 5'd0);
        force dut.retired_q = 32'hFFFFFFFF;
        #1;
        release dut.retired_q;
        chk("preload retired", bus.retired, 32'hFFFFFFFF);
        drive(1'b1, 32'h0400, 32'h0000_0040, 32'd0, LD_LW, 1'b0, 1'b1, 5'd4);
        step();
        chk("wrap retired", bus.retired, 32'd0);
        step();
        chk("wrap+1 retired", bus.retired, 32'd1);
        exp_ret = 32'd1;

        // Misaligned word load.
        drive(1'b1, 32'h0500, 32'h0000_1002, 32'h8899AABB, LD_LW, 1'b1, 1'b1, 5'd7);
        step();
        exp_ret = exp_ret + 32'd1;
        chk("lw@2 retired", bus.retired, exp_ret);
`ifdef MEM_WB_ALIGN_CHECK_EN
        chk("lw@2 adel", {31'd0, bus.adel}, 32'd1);
        chk("lw@2 w_regwrite", {31'd0, bus.w_regwrite}, 32'd0);
        drive(1'b1, 32'h0508, 32'h0000_1001, 32'h8899AABB, LD_LH, 1'b1, 1'b1, 5'd7);
        step();
        chk("lh@1 adel", {31'd0, bus.adel}, 32'd1);
        drive(1'b1, 32'h0510, 32'h0000_1003, 32'h8899AABB, LD_LB, 1'b1, 1'b1, 5'd7);
        step();
        chk("lb@3 adel", {31'd0, bus.adel}, 32'd0);
        chk("lb@3 w_regwrite", {31'd0, bus.w_regwrite}, 32'd1);
`else
        chk("lw@2 w_wd", bus.w_wd, 32'h8899AABB);
        chk("lw@2 w_regwrite", {31'd0, bus.w_regwrite}, 32'd1);
`endif

        // Final reset overriding stall and flush with a valid instruction pending.
        drive(1'b1, 32'h0600, 32'h0000_1003, 32'h8899AABB, LD_LB, 1'b1, 1'b1, 5'd9);
        rst = 1'b1; stall = 1'b1; flush = 1'b1;
        step();
        chk_zero("rst+stall+flush");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have: clk  input  1  rising-edge clock.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-high; clock clk.
REQ-003 SHALL have: stall  input  1  hold all stage registers this cycle.
REQ-004 SHALL have: flush  input  1  load a bubble this cycle.
REQ-005 SHALL have: m_valid  input  1  MEM-stage entry is a real instruction.
REQ-006 SHALL have: m_pc8  input  32  PC+8 of the MEM-stage instruction.
REQ-007 SHALL have: m_aluout  input  32  ALU result, also the data-memory byte address.
REQ-008 SHALL have: m_dmo  input  32  full word read from data memory at m_aluout[13:2].
REQ-009 SHALL have: m_ldctr  input  3  load type code.
REQ-010 SHALL have: m_memtoreg  input  1  write-back source: 1 = load data, 0 = m_aluout.
REQ-011 SHALL have: m_regwrite  input  1  instruction writes the register file.
REQ-012 SHALL have: m_wa  input  5  destination register.
REQ-013 SHALL have: w_valid  output  1;  w_pc8  output  32;  w_wa  output  5;  w_regwrite  output  1;  w_wd  output  32 (write-back data).
REQ-014 SHALL have: retired  output  32  count of valid instructions captured.
REQ-015 SHALL have, only under ALIGN_CHECK_EN: adel  output  1  misaligned-load flag for the WB entry.

Function
REQ-016 SHALL capture all m_* inputs on the rising clk edge when rst=0, stall=0 and flush=0.
REQ-017 SHALL hold every register, including retired, when stall=1 and rst=0.
REQ-018 SHALL load a bubble (valid=0, regwrite=0, wa=0, pc8=0, aluout=0, dmo=0, memtoreg=0, ldctr=LD_LW) when flush=1; flush overrides stall; rst overrides both.
REQ-019 SHALL derive w_wd combinationally from the registered fields only: zero-cycle latency after the register, one-cycle latency from the m_* inputs.
REQ-020 SHALL, when memtoreg=1, select the byte or halfword using registered aluout[1:0].
REQ-021 SHALL apply these load rules:
  - LD_LW: the whole word.
  - LD_LH: sign-extended halfword (addr[1]=1 selects bits 31:16, else bits 15:0).
  - LD_LHU: the same halfword, zero-extended.
  - LD_LB: sign-extended byte [8k+7:8k], k = addr[1:0].
  - LD_LBU: the same byte, zero-extended.
REQ-022 SHALL treat reserved ldctr codes (5-7) as LD_LW.
REQ-023 SHALL output w_wd = registered aluout when memtoreg=0.
REQ-024 SHALL drive w_regwrite = registered regwrite AND valid AND (wa != 0).
REQ-025 SHALL increment retired by 1 on each edge that captures m_valid=1 (rst=0, stall=0, flush=0); retired SHALL wrap from 32'hFFFFFFFF to 0.

Reset
REQ-026 SHALL, on rst=1 at a clk edge, clear every register to the bubble of REQ-018 and clear retired to 0.
REQ-027 SHALL, after reset, output w_valid=0, w_regwrite=0, w_wa=0, w_pc8=0, w_wd=0, retired=0, adel=0.
REQ-028 SHALL let rst asserted during a stall or flush win, with no partial update.

Configuration
REQ-029 SHALL use the macro MEM_WB_ALIGN_CHECK_EN.
REQ-030 SHALL, with MEM_WB_ALIGN_CHECK_EN defined:
  - drive adel=1 when valid and memtoreg and either (LD_LW and addr[1:0] != 0) or ((LD_LH or LD_LHU) and addr[0] = 1);
  - force w_regwrite=0 while adel=1;
  - still count the entry in retired.
REQ-031 SHALL, without MEM_WB_ALIGN_CHECK_EN, have no adel port, perform no misalignment check, ignore the low address bits that do not apply to the load width, and leave w_regwrite unaffected.

Structure
REQ-032 SHALL take LD_LW=0, LD_LH=1, LD_LHU=2, LD_LB=3, LD_LBU=4 from the shared header/package, alongside the existing dm store codes.
REQ-033 SHALL place the extension logic in one combinational sub-module, load_ext (inputs word, addr[1:0], ldctr; output 32-bit data).

Verification
REQ-034 SHALL cover: m_dmo=32'h8899AABB, aluout=..03, LD_LB, memtoreg=1, wa=5 -> next cycle w_wd=32'hFFFFFF88, w_regwrite=1.
REQ-035 SHALL cover: the same word, aluout=..02, LD_LHU -> w_wd=32'h00008899; with LD_LH -> 32'hFFFF8899.
REQ-036 SHALL cover: capture one instruction, then stall=1 for 3 cycles with changing inputs -> outputs and retired unchanged; flush=1 -> w_valid=0, w_regwrite=0, retired unchanged.
REQ-037 SHALL cover: retired preloaded to 32'hFFFFFFFF (by valid count or force) plus one valid capture -> retired=0.
REQ-038 SHALL cover: wa=0 with regwrite=1 -> w_regwrite=0; rst=1 together with flush=1 and stall=1 -> all outputs 0.
REQ-039 SHALL cover, with MEM_WB_ALIGN_CHECK_EN: LD_LW at aluout=..02 -> adel=1, w_regwrite=0, retired incremented.
